// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// mcause codes, mstatus/mie bit positions and FSM state encodings.
package trap_sequencer_pkg;

  // CSR addresses driven on the single CSR write port
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Exception codes (mcause interrupt bit clear)
  localparam logic [4:0] CAUSE_IAM    = 5'd0;
  localparam logic [4:0] CAUSE_ILL    = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK = 5'd3;
  localparam logic [4:0] CAUSE_LAM    = 5'd4;
  localparam logic [4:0] CAUSE_SAM    = 5'd6;
  localparam logic [4:0] CAUSE_ECALL  = 5'd11;

  // Interrupt codes (mcause interrupt bit set)
  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  // mstatus fields
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  // mie enable bits
  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  // FSM states, kept as plain constants so older code can compare against them
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_W_EPC    = 3'd1;
  localparam logic [2:0] ST_W_CAUSE  = 3'd2;
  localparam logic [2:0] ST_W_TVAL   = 3'd3;
  localparam logic [2:0] ST_W_STAT   = 3'd4;
  localparam logic [2:0] ST_RET_STAT = 3'd5;
  localparam logic [2:0] ST_REDIR    = 3'd6;

  // Result of trap prioritisation
  typedef struct packed {
    logic       valid;     // some trap must be taken
    logic       is_int;    // interrupt rather than exception
    logic [4:0] code;      // mcause code
    logic       has_tval;  // mtval carries i_badval
  } trap_sel_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder: picks the highest-priority pending
// exception, or failing that the highest-priority enabled interrupt.
module trap_prio_enc
  import trap_sequencer_pkg::*;
(
  input  logic      i_exc_iam,
  input  logic      i_exc_ill,
  input  logic      i_exc_ebreak,
  input  logic      i_exc_ecall,
  input  logic      i_exc_lam,
  input  logic      i_exc_sam,
  input  logic      i_ext_int,
  input  logic      i_sw_int,
  input  logic      i_tmr_int,
  input  logic      i_meie,
  input  logic      i_msie,
  input  logic      i_mtie,
  input  logic      i_glob_mie,
  output trap_sel_t o_sel
);

  logic w_ext_take;
  logic w_sw_take;
  logic w_tmr_take;

  assign w_ext_take = i_glob_mie & i_ext_int & i_meie;
  assign w_sw_take  = i_glob_mie & i_sw_int  & i_msie;
  assign w_tmr_take = i_glob_mie & i_tmr_int & i_mtie;

  // Fixed-priority selection: exceptions first, then interrupts
  always_comb begin
    o_sel = '0;
    if (i_exc_iam) begin
      o_sel = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_IAM, has_tval: 1'b1};
    end else if (i_exc_ill) begin
      o_sel = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_ILL, has_tval: 1'b1};
    end else if (i_exc_ebreak) begin
      o_sel = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_EBREAK, has_tval: 1'b0};
    end else if (i_exc_ecall) begin
      o_sel = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_ECALL, has_tval: 1'b0};
    end else if (i_exc_lam) begin
      o_sel = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_LAM, has_tval: 1'b1};
    end else if (i_exc_sam) begin
      o_sel = '{valid: 1'b1, is_int: 1'b0, code: CAUSE_SAM, has_tval: 1'b1};
    end else if (w_ext_take) begin
      o_sel = '{valid: 1'b1, is_int: 1'b1, code: CAUSE_MEI, has_tval: 1'b0};
    end else if (w_sw_take) begin
      o_sel = '{valid: 1'b1, is_int: 1'b1, code: CAUSE_MSI, has_tval: 1'b0};
    end else if (w_tmr_take) begin
      o_sel = '{valid: 1'b1, is_int: 1'b1, code: CAUSE_MTI, has_tval: 1'b0};
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: captures a trap or mret in IDLE, then
// drives the CSR write port one CSR per cycle and ends with a single
// PC-redirect pulse. The pipeline is stalled for the whole sequence.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_ext_int,
  input  logic            i_sw_int,
  input  logic            i_tmr_int,
  input  logic [XLEN-1:0] i_mie,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_exc_iam,
  input  logic            i_exc_ill,
  input  logic            i_exc_ebreak,
  input  logic            i_exc_ecall,
  input  logic            i_exc_lam,
  input  logic            i_exc_sam,
  input  logic            i_is_mret,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_badval,
  output logic            o_csr_we,
  output logic [11:0]     o_csr_addr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_stall,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc
);

  logic [2:0]      r_state;
  logic [XLEN-2:0] r_pc;      // halfword-aligned PC, bit 0 is always written as 0
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic            r_mret;    // sequence in flight is an mret, not a trap

  trap_sel_t       w_sel;
  logic            w_idle;
  logic            w_capture;
  logic [XLEN-1:0] w_stat_trap;
  logic [XLEN-1:0] w_stat_ret;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vec_pc;
  logic            w_vectored;
  logic            w_unused;

  trap_prio_enc u_prio (
    .i_exc_iam    (i_exc_iam),
    .i_exc_ill    (i_exc_ill),
    .i_exc_ebreak (i_exc_ebreak),
    .i_exc_ecall  (i_exc_ecall),
    .i_exc_lam    (i_exc_lam),
    .i_exc_sam    (i_exc_sam),
    .i_ext_int    (i_ext_int),
    .i_sw_int     (i_sw_int),
    .i_tmr_int    (i_tmr_int),
    .i_meie       (i_mie[MIE_MEIE]),
    .i_msie       (i_mie[MIE_MSIE]),
    .i_mtie       (i_mie[MIE_MTIE]),
    .i_glob_mie   (i_mstatus[MSTATUS_MIE]),
    .o_sel        (w_sel)
  );

  // Capture is blocked while reset is held so stall cannot leak out of reset
  assign w_idle    = (r_state == ST_IDLE);
  assign w_capture = reset & w_idle & ~i_flush & (w_sel.valid | i_is_mret);

  // Trap vector: base always, plus 4*cause in vectored mode for interrupts
  assign w_base     = {i_mtvec[XLEN-1:2], 2'b00};
  assign w_vectored = (i_mtvec[1:0] == 2'b01) & r_cause[XLEN-1];
  assign w_vec_pc   = w_base + {{(XLEN-7){1'b0}}, r_cause[4:0], 2'b00};

  // Bits the sequencer never looks at
  assign w_unused = ^{i_mie[XLEN-1:12], i_mie[10:8], i_mie[6:4], i_mie[2:0], i_pc[0]};

  // mstatus images for trap entry and mret, built from the live CSR value
  always_comb begin
    w_stat_trap                       = i_mstatus;
    w_stat_trap[MSTATUS_MPIE]         = i_mstatus[MSTATUS_MIE];
    w_stat_trap[MSTATUS_MIE]          = 1'b0;
    w_stat_trap[MSTATUS_MPP_LO +: 2]  = 2'b11;
    w_stat_ret                        = i_mstatus;
    w_stat_ret[MSTATUS_MIE]           = i_mstatus[MSTATUS_MPIE];
    w_stat_ret[MSTATUS_MPIE]          = 1'b1;
    w_stat_ret[MSTATUS_MPP_LO +: 2]   = 2'b11;
  end

  // State machine and trap capture; events outside IDLE are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_cause <= '0;
      r_tval  <= '0;
      r_mret  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!i_flush) begin
            if (w_sel.valid) begin
              r_pc    <= i_pc[XLEN-1:1];
              r_cause <= {w_sel.is_int, {(XLEN-6){1'b0}}, w_sel.code};
              r_tval  <= w_sel.has_tval ? i_badval : '0;
              r_mret  <= 1'b0;
              r_state <= ST_W_EPC;
            end else if (i_is_mret) begin
              r_mret  <= 1'b1;
              r_state <= ST_RET_STAT;
            end
          end
        end
        ST_W_EPC:    r_state <= ST_W_CAUSE;
        ST_W_CAUSE:  r_state <= ST_W_TVAL;
        ST_W_TVAL:   r_state <= ST_W_STAT;
        ST_W_STAT:   r_state <= ST_REDIR;
        ST_RET_STAT: r_state <= ST_REDIR;
        ST_REDIR:    r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Output decode: one CSR write per state, redirect in REDIR
  always_comb begin
    o_csr_we      = 1'b0;
    o_csr_addr    = 12'h000;
    o_csr_wdata   = '0;
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    o_stall       = ~w_idle | w_capture;
    case (r_state)
      ST_W_EPC: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MEPC;
        o_csr_wdata = {r_pc, 1'b0};
      end
      ST_W_CAUSE: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MCAUSE;
        o_csr_wdata = r_cause;
      end
      ST_W_TVAL: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MTVAL;
        o_csr_wdata = r_tval;
      end
      ST_W_STAT: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        o_csr_wdata = w_stat_trap;
      end
      ST_RET_STAT: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        o_csr_wdata = w_stat_ret;
      end
      ST_REDIR: begin
        o_redirect    = 1'b1;
        o_redirect_pc = r_mret ? i_mepc : (w_vectored ? w_vec_pc : w_base);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a table of single-event vectors
// plus hand-written sequences for busy-time events and mid-sequence reset.
// Expected CSR writes and redirects are queued with their cycle numbers
// when stimulus is applied and popped as the DUT produces them.
module tb_trap_sequencer;

  logic        clk;
  logic        reset;
  logic        i_flush;
  logic        i_ext_int, i_sw_int, i_tmr_int;
  logic [31:0] i_mie, i_mstatus, i_mtvec, i_mepc;
  logic        i_exc_iam, i_exc_ill, i_exc_ebreak, i_exc_ecall, i_exc_lam, i_exc_sam;
  logic        i_is_mret;
  logic [31:0] i_pc, i_badval;
  logic        o_csr_we;
  logic [11:0] o_csr_addr;
  logic [31:0] o_csr_wdata;
  logic        o_stall;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;

  trap_sequencer #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (i_flush),
    .i_ext_int     (i_ext_int),
    .i_sw_int      (i_sw_int),
    .i_tmr_int     (i_tmr_int),
    .i_mie         (i_mie),
    .i_mstatus     (i_mstatus),
    .i_mtvec       (i_mtvec),
    .i_mepc        (i_mepc),
    .i_exc_iam     (i_exc_iam),
    .i_exc_ill     (i_exc_ill),
    .i_exc_ebreak  (i_exc_ebreak),
    .i_exc_ecall   (i_exc_ecall),
    .i_exc_lam     (i_exc_lam),
    .i_exc_sam     (i_exc_sam),
    .i_is_mret     (i_is_mret),
    .i_pc          (i_pc),
    .i_badval      (i_badval),
    .o_csr_we      (o_csr_we),
    .o_csr_addr    (o_csr_addr),
    .o_csr_wdata   (o_csr_wdata),
    .o_stall       (o_stall),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = CSR write, 1 = redirect
  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  // exc = {sam,lam,ecall,ebreak,ill,iam}; irq = {tmr,sw,ext}
  // kind: 0 = no sequence, 1 = trap, 2 = mret
  typedef struct {
    logic [5:0]  exc;
    logic [2:0]  irq;
    logic        mret;
    logic        flush;
    logic [31:0] mie, mstatus, mtvec, mepc, pc, badval;
    int          kind;
    logic [31:0] e_cause, e_tval, e_stat, e_tgt;
  } vec_t;

  exp_t q[$];
  vec_t vecs[18];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic vec_t mk(logic [5:0] exc, logic [2:0] irq, logic mret, logic flush,
                              logic [31:0] mie, logic [31:0] mst, logic [31:0] mtvec,
                              logic [31:0] mepc, logic [31:0] pc, logic [31:0] badval,
                              int kind, logic [31:0] cause, logic [31:0] tval,
                              logic [31:0] stat, logic [31:0] tgt);
    vec_t v;
    v.exc = exc; v.irq = irq; v.mret = mret; v.flush = flush;
    v.mie = mie; v.mstatus = mst; v.mtvec = mtvec; v.mepc = mepc;
    v.pc = pc; v.badval = badval; v.kind = kind;
    v.e_cause = cause; v.e_tval = tval; v.e_stat = stat; v.e_tgt = tgt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int kind, logic [11:0] addr, logic [31:0] data, int c);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
    q.push_back(e);
  endtask

  // Compare whatever the DUT is producing this cycle against the queue head
  task automatic monitor();
    exp_t e;
    if (o_csr_we || o_redirect) begin
      if (o_csr_we)
        $display("cyc %0d csr_write addr=0x%03h data=0x%08h", cyc, o_csr_addr, o_csr_wdata);
      else
        $display("cyc %0d redirect pc=0x%08h", cyc, o_redirect_pc);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: we=%0b redirect=%0b expected nothing (cyc %0d)",
                 o_csr_we, o_redirect, cyc);
      end else begin
        e = q.pop_front();
        chk("out_kind", {31'd0, o_redirect}, e.kind);
        chk("out_cycle", cyc, e.cyc);
        if (e.kind == 0) begin
          chk("csr_addr", {20'd0, o_csr_addr}, {20'd0, e.addr});
          chk("csr_wdata", o_csr_wdata, e.data);
        end else begin
          chk("redirect_pc", o_redirect_pc, e.data);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_events();
    {i_exc_sam, i_exc_lam, i_exc_ecall, i_exc_ebreak, i_exc_ill, i_exc_iam} = 6'b0;
    {i_tmr_int, i_sw_int, i_ext_int} = 3'b0;
    i_is_mret = 1'b0;
    i_flush   = 1'b0;
  endtask

  task automatic push_trap(logic [31:0] pc, logic [31:0] cause, logic [31:0] tval,
                           logic [31:0] stat, logic [31:0] tgt, int n);
    push(0, 12'h341, {pc[31:1], 1'b0}, n + 1);
    push(0, 12'h342, cause, n + 2);
    push(0, 12'h343, tval, n + 3);
    push(0, 12'h300, stat, n + 4);
    push(1, 12'h000, tgt, n + 5);
  endtask

  task automatic run_vec(vec_t v);
    {i_exc_sam, i_exc_lam, i_exc_ecall, i_exc_ebreak, i_exc_ill, i_exc_iam} = v.exc;
    {i_tmr_int, i_sw_int, i_ext_int} = v.irq;
    i_is_mret = v.mret;
    i_flush   = v.flush;
    i_mie     = v.mie;
    i_mstatus = v.mstatus;
    i_mtvec   = v.mtvec;
    i_mepc    = v.mepc;
    i_pc      = v.pc;
    i_badval  = v.badval;
    if (v.kind == 1) begin
      push_trap(v.pc, v.e_cause, v.e_tval, v.e_stat, v.e_tgt, cyc);
    end else if (v.kind == 2) begin
      push(0, 12'h300, v.e_stat, cyc + 1);
      push(1, 12'h000, v.e_tgt, cyc + 2);
    end
    #1;
    chk("capture_stall", {31'd0, o_stall}, (v.kind != 0) ? 32'd1 : 32'd0);
    step();
    clear_events();
    repeat (6) step();
    chk("seq_complete_qsize", q.size(), 0);
    chk("idle_stall", {31'd0, o_stall}, 0);
    q.delete();
  endtask

  initial begin
    int n;
    vecs[0]  = mk(6'h08, 3'h0, 0, 0, 32'h0,   32'h8,        32'h200,      32'h0,        32'h100, 32'h55,   1, 32'd11,        32'h0,    32'h1880,     32'h200);
    vecs[1]  = mk(6'h12, 3'h0, 0, 0, 32'h0,   32'h0,        32'h200,      32'h0,        32'h204, 32'hDEAD, 1, 32'd2,         32'hDEAD, 32'h1800,     32'h200);
    vecs[2]  = mk(6'h00, 3'h4, 0, 0, 32'h80,  32'h8,        32'h301,      32'h0,        32'h400, 32'h77,   1, 32'h80000007,  32'h0,    32'h1880,     32'h31C);
    vecs[3]  = mk(6'h00, 3'h4, 0, 0, 32'h80,  32'h0,        32'h301,      32'h0,        32'h400, 32'h0,    0, 32'h0,         32'h0,    32'h0,        32'h0);
    vecs[4]  = mk(6'h00, 3'h0, 1, 0, 32'h0,   32'h80,       32'h200,      32'h104,      32'h500, 32'h0,    2, 32'h0,         32'h0,    32'h1888,     32'h104);
    vecs[5]  = mk(6'h07, 3'h0, 0, 0, 32'h0,   32'h1888,     32'h1000,     32'h0,        32'h121, 32'h123,  1, 32'd0,         32'h123,  32'h1880,     32'h1000);
    vecs[6]  = mk(6'h00, 3'h7, 0, 0, 32'h888, 32'h8,        32'h401,      32'h0,        32'h600, 32'h0,    1, 32'h8000000B,  32'h0,    32'h1880,     32'h42C);
    vecs[7]  = mk(6'h00, 3'h6, 0, 0, 32'h888, 32'h8,        32'h401,      32'h0,        32'h604, 32'h0,    1, 32'h80000003,  32'h0,    32'h1880,     32'h40C);
    vecs[8]  = mk(6'h00, 3'h3, 0, 0, 32'h80,  32'h8,        32'h401,      32'h0,        32'h608, 32'h0,    0, 32'h0,         32'h0,    32'h0,        32'h0);
    vecs[9]  = mk(6'h08, 3'h1, 0, 0, 32'h800, 32'h8,        32'h401,      32'h0,        32'h700, 32'h99,   1, 32'd11,        32'h0,    32'h1880,     32'h400);
    vecs[10] = mk(6'h04, 3'h0, 1, 0, 32'h0,   32'h0,        32'h200,      32'h104,      32'h704, 32'h99,   1, 32'd3,         32'h0,    32'h1800,     32'h200);
    vecs[11] = mk(6'h30, 3'h0, 0, 0, 32'h0,   32'h0,        32'h200,      32'h0,        32'h708, 32'hBEEF, 1, 32'd4,         32'hBEEF, 32'h1800,     32'h200);
    vecs[12] = mk(6'h28, 3'h0, 0, 0, 32'h0,   32'h0,        32'h200,      32'h0,        32'h70C, 32'hBEEF, 1, 32'd11,        32'h0,    32'h1800,     32'h200);
    vecs[13] = mk(6'h20, 3'h0, 0, 0, 32'h0,   32'h0,        32'h200,      32'h0,        32'h710, 32'h1234, 1, 32'd6,         32'h1234, 32'h1800,     32'h200);
    vecs[14] = mk(6'h08, 3'h0, 0, 1, 32'h0,   32'h8,        32'h200,      32'h0,        32'h714, 32'h0,    0, 32'h0,         32'h0,    32'h0,        32'h0);
    vecs[15] = mk(6'h00, 3'h1, 0, 0, 32'h800, 32'h8,        32'hFFFFFFFD, 32'h0,        32'h800, 32'h0,    1, 32'h8000000B,  32'h0,    32'h1880,     32'h28);
    vecs[16] = mk(6'h00, 3'h0, 1, 0, 32'h0,   32'h8,        32'h200,      32'hFFFFFFF0, 32'h804, 32'h0,    2, 32'h0,         32'h0,    32'h1880,     32'hFFFFFFF0);
    vecs[17] = mk(6'h08, 3'h0, 0, 0, 32'h0,   32'hA5A50008, 32'h200,      32'h0,        32'h900, 32'h0,    1, 32'd11,        32'h0,    32'hA5A51880, 32'h200);

    // Reset state
    reset = 1'b0;
    clear_events();
    i_mie = '0; i_mstatus = '0; i_mtvec = '0; i_mepc = '0; i_pc = '0; i_badval = '0;
    #3;
    chk("rst_we", {31'd0, o_csr_we}, 0);
    chk("rst_addr", {20'd0, o_csr_addr}, 0);
    chk("rst_wdata", o_csr_wdata, 0);
    chk("rst_stall", {31'd0, o_stall}, 0);
    chk("rst_redirect", {31'd0, o_redirect}, 0);
    chk("rst_redirect_pc", o_redirect_pc, 0);
    step();
    step();
    reset = 1'b1;
    step();

    // Table-driven single-event vectors
    for (int i = 0; i < 18; i++) begin
      $display("vector %0d kind=%0d pc=0x%08h", i, vecs[i].kind, vecs[i].pc);
      run_vec(vecs[i]);
    end

    // Events presented while busy are ignored; only the first trap runs
    i_mstatus = 32'h8; i_mtvec = 32'h200; i_mie = 32'h800;
    i_pc = 32'hA00; i_badval = 32'h0;
    i_exc_ecall = 1'b1;
    push_trap(32'hA00, 32'd11, 32'h0, 32'h1880, 32'h200, cyc);
    step();
    i_ext_int = 1'b1; i_is_mret = 1'b1; i_pc = 32'hB04;
    step();
    step();
    step();
    clear_events();
    repeat (6) step();
    chk("busy_ignore_qsize", q.size(), 0);
    q.delete();

    // Reset asserted in W_CAUSE: everything drops at once, nothing more is written
    i_pc = 32'hC00;
    i_exc_ecall = 1'b1;
    push(0, 12'h341, 32'hC00, cyc + 1);
    step();
    clear_events();
    @(posedge clk);
    cyc++;
    #1;
    chk("wcause_we", {31'd0, o_csr_we}, 1);
    chk("wcause_addr", {20'd0, o_csr_addr}, 32'h342);
    reset = 1'b0;
    #1;
    chk("midrst_we", {31'd0, o_csr_we}, 0);
    chk("midrst_stall", {31'd0, o_stall}, 0);
    chk("midrst_redirect", {31'd0, o_redirect}, 0);
    chk("midrst_addr", {20'd0, o_csr_addr}, 0);
    chk("midrst_wdata", o_csr_wdata, 0);
    @(negedge clk);
    monitor();
    step();
    chk("rsthold_stall", {31'd0, o_stall}, 0);
    chk("rsthold_we", {31'd0, o_csr_we}, 0);
    reset = 1'b1;
    repeat (6) step();
    chk("midrst_qsize", q.size(), 0);
    q.delete();

    // mret right after reset release works normally (capture N -> redirect N+2)
    i_mstatus = 32'h80; i_mepc = 32'h104;
    i_is_mret = 1'b1;
    n = cyc;
    push(0, 12'h300, 32'h1888, n + 1);
    push(1, 12'h000, 32'h104, n + 2);
    step();
    clear_events();
    repeat (4) step();
    chk("post_rst_mret_qsize", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
